// File: rtl/spi_alu_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | spi_alu_pkg: shared encodings, widths and frame layout for the sequencer |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
package spi_alu_pkg;

  localparam int FRAME_W        = 20;
  localparam int OP_W           = 4;
  localparam int DATA_W         = 8;
  localparam int RES_W          = 16;
  localparam int NUM_OPS        = 12;
  localparam int TIMEOUT_CYCLES = 64;

  localparam int OP_MSB = 19;
  localparam int OP_LSB = 16;
  localparam int A_MSB  = 15;
  localparam int A_LSB  = 8;
  localparam int B_MSB  = 7;
  localparam int B_LSB  = 0;

  localparam int STAT_OVERRUN = 3;
  localparam int STAT_TIMEOUT = 2;
  localparam int STAT_ALU_ERR = 1;
  localparam int STAT_INVALID = 0;

  localparam logic [OP_W-1:0] OP_ADD = 4'd0;
  localparam logic [OP_W-1:0] OP_SUB = 4'd1;
  localparam logic [OP_W-1:0] OP_MUL = 4'd2;
  localparam logic [OP_W-1:0] OP_AND = 4'd3;
  localparam logic [OP_W-1:0] OP_OR  = 4'd4;
  localparam logic [OP_W-1:0] OP_XOR = 4'd5;
  localparam logic [OP_W-1:0] OP_NOT = 4'd6;
  localparam logic [OP_W-1:0] OP_SHL = 4'd7;
  localparam logic [OP_W-1:0] OP_SHR = 4'd8;
  localparam logic [OP_W-1:0] OP_INC = 4'd9;
  localparam logic [OP_W-1:0] OP_DEC = 4'd10;
  localparam logic [OP_W-1:0] OP_CMP = 4'd11;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ISSUE    = 2'd1,
    ST_WAIT_ALU = 2'd2,
    ST_LOAD     = 2'd3
  } state_t;

  function automatic logic op_is_valid(input logic [OP_W-1:0] op);
    return op < OP_W'(NUM_OPS);
  endfunction

endpackage
`default_nettype wire

// File: rtl/spi_alu_pending_buf.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | spi_alu_pending_buf: one-entry frame holding slot with overrun detect    |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module spi_alu_pending_buf
  import spi_alu_pkg::*;
(
  input  logic               clk,
  input  logic               reset_n,
  input  logic               i_wr,
  input  logic [FRAME_W-1:0] i_wr_data,
  input  logic               i_consume,
  output logic               o_valid,
  output logic [FRAME_W-1:0] o_data,
  output logic               o_overrun
);

  logic               r_valid;
  logic [FRAME_W-1:0] r_data;
  logic               w_accept;

  // A write in the same cycle as a consume refills the slot.
  assign w_accept = i_wr && (!r_valid || i_consume);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (w_accept) begin
      r_valid <= 1'b1;
      r_data  <= i_wr_data;
    end else if (i_consume) begin
      r_valid <= 1'b0;
    end
  end

  assign o_valid   = r_valid;
  assign o_data    = r_data;
  assign o_overrun = i_wr && r_valid && !i_consume;

endmodule
`default_nettype wire

// File: rtl/spi_alu_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | spi_alu_sequencer: SPI frame -> ALU op -> TX response word sequencer     |
// | Optional ALU watchdog: define SPI_ALU_TIMEOUT_EN.            Rev 1.0     |
// +--------------------------------------------------------------------------+
module spi_alu_sequencer
  import spi_alu_pkg::*;
(
  input  logic               clk,
  input  logic               reset_n,
  input  logic               frame_valid,
  input  logic [FRAME_W-1:0] frame_data,
  output logic               alu_start,
  output logic [OP_W-1:0]    alu_op,
  output logic [DATA_W-1:0]  alu_a,
  output logic [DATA_W-1:0]  alu_b,
  input  logic               alu_done,
  input  logic [RES_W-1:0]   alu_result,
  input  logic               alu_err,
  output logic               tx_load,
  output logic [FRAME_W-1:0] tx_data,
  output logic               busy
);

  state_t             r_state;
  state_t             w_next_state;

  logic               w_pend_valid;
  logic [FRAME_W-1:0] w_pend_data;
  logic               w_pend_ovr;
  logic               w_pend_wr;
  logic               w_pend_consume;

  logic               w_cap;
  logic [FRAME_W-1:0] w_cap_frame;
  logic               w_cap_op_ok;
  logic               w_alu_accept;
  logic               w_timeout;

  logic [OP_W-1:0]    r_op;
  logic [DATA_W-1:0]  r_a;
  logic [DATA_W-1:0]  r_b;
  logic [RES_W-1:0]   r_result;
  logic               r_overrun;
  logic               r_tmo;
  logic               r_err;
  logic               r_inv;
  logic [3:0]         w_status;

  // Pending is drained whenever the FSM can take a new command (IDLE or LOAD).
  assign w_pend_wr      = frame_valid && ((r_state != ST_IDLE) || w_pend_valid);
  assign w_pend_consume = w_pend_valid && ((r_state == ST_IDLE) || (r_state == ST_LOAD));
  assign w_cap          = w_pend_consume || ((r_state == ST_IDLE) && frame_valid);
  assign w_cap_frame    = w_pend_valid ? w_pend_data : frame_data;
  assign w_cap_op_ok    = op_is_valid(w_cap_frame[OP_MSB:OP_LSB]);
  assign w_alu_accept   = (r_state == ST_WAIT_ALU) && alu_done;

  spi_alu_pending_buf u_pending (
    .clk       (clk),
    .reset_n   (reset_n),
    .i_wr      (w_pend_wr),
    .i_wr_data (frame_data),
    .i_consume (w_pend_consume),
    .o_valid   (w_pend_valid),
    .o_data    (w_pend_data),
    .o_overrun (w_pend_ovr)
  );

`ifdef SPI_ALU_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES);
  logic [WD_W-1:0] r_wd_cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wd_cnt <= '0;
    end else if (r_state == ST_WAIT_ALU) begin
      r_wd_cnt <= r_wd_cnt + WD_W'(1);
    end else begin
      r_wd_cnt <= '0;
    end
  end

  // A done arriving on the expiry cycle takes priority over the timeout.
  assign w_timeout = (r_state == ST_WAIT_ALU) && !alu_done &&
                     (r_wd_cnt == WD_W'(TIMEOUT_CYCLES - 1));
`else
  assign w_timeout = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    alu_start    = 1'b0;
    tx_load      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_cap) begin
          w_next_state = w_cap_op_ok ? ST_ISSUE : ST_LOAD;
        end
      end
      ST_ISSUE: begin
        alu_start    = 1'b1;
        w_next_state = ST_WAIT_ALU;
      end
      ST_WAIT_ALU: begin
        if (w_alu_accept || w_timeout) begin
          w_next_state = ST_LOAD;
        end
      end
      ST_LOAD: begin
        tx_load = 1'b1;
        if (w_cap) begin
          w_next_state = w_cap_op_ok ? ST_ISSUE : ST_LOAD;
        end else begin
          w_next_state = ST_IDLE;
        end
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_op      <= '0;
      r_a       <= '0;
      r_b       <= '0;
      r_result  <= '0;
      r_tmo     <= 1'b0;
      r_err     <= 1'b0;
      r_inv     <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      // Operands only change on a valid capture so they stay put until the next issue.
      if (w_cap && w_cap_op_ok) begin
        r_op <= w_cap_frame[OP_MSB:OP_LSB];
        r_a  <= w_cap_frame[A_MSB:A_LSB];
        r_b  <= w_cap_frame[B_MSB:B_LSB];
      end

      if (w_cap && !w_cap_op_ok) begin
        r_result <= '0;
        r_inv    <= 1'b1;
        r_err    <= 1'b0;
        r_tmo    <= 1'b0;
      end else if (w_alu_accept) begin
        r_result <= alu_result;
        r_err    <= alu_err;
        r_inv    <= 1'b0;
        r_tmo    <= 1'b0;
      end else if (w_timeout) begin
        r_result <= '0;
        r_tmo    <= 1'b1;
        r_err    <= 1'b0;
        r_inv    <= 1'b0;
      end

      if (tx_load) begin
        r_overrun <= w_pend_ovr;
      end else begin
        r_overrun <= r_overrun | w_pend_ovr;
      end
    end
  end

  always_comb begin
    w_status               = 4'b0000;
    w_status[STAT_OVERRUN] = r_overrun;
    w_status[STAT_TIMEOUT] = r_tmo;
    w_status[STAT_ALU_ERR] = r_err;
    w_status[STAT_INVALID] = r_inv;
  end

  assign tx_data = tx_load ? {w_status, r_result} : '0;
  assign alu_op  = r_op;
  assign alu_a   = r_a;
  assign alu_b   = r_b;
  assign busy    = (r_state != ST_IDLE) || w_pend_valid;

endmodule
`default_nettype wire

// File: tb/tb_spi_alu_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_spi_alu_sequencer: self-checking bench with ALU responder and model   |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_spi_alu_sequencer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        frame_valid;
  logic [19:0] frame_data;
  logic        alu_start;
  logic [3:0]  alu_op;
  logic [7:0]  alu_a;
  logic [7:0]  alu_b;
  logic        alu_done;
  logic [15:0] alu_result;
  logic        alu_err;
  logic        tx_load;
  logic [19:0] tx_data;
  logic        busy;

  spi_alu_sequencer dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .frame_valid (frame_valid),
    .frame_data  (frame_data),
    .alu_start   (alu_start),
    .alu_op      (alu_op),
    .alu_a       (alu_a),
    .alu_b       (alu_b),
    .alu_done    (alu_done),
    .alu_result  (alu_result),
    .alu_err     (alu_err),
    .tx_load     (tx_load),
    .tx_data     (tx_data),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;
  int load_count  = 0;
  int start_count = 0;

  logic [19:0] exp_q[$];
  logic [19:0] cmd_q[$];
  int          lat_q[$];
  logic        err_q[$];
  int          load_cyc_q[$];
  int          start_cyc_q[$];

  typedef struct {
    logic [19:0] frame;
    int          lat;
    logic        err;
    logic [19:0] exp_tx;
    int          exp_lat;
  } vec_t;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic logic [15:0] alu_fn(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    case (op)
      4'd0:    return {8'd0, a} + {8'd0, b};
      4'd1:    return {8'd0, a} - {8'd0, b};
      4'd2:    return {8'd0, a} * {8'd0, b};
      4'd3:    return {8'd0, a & b};
      4'd4:    return {8'd0, a | b};
      4'd5:    return {8'd0, a ^ b};
      default: return {a, b} ^ {4{op}};
    endcase
  endfunction

  // Response word from the command alone: invalid opcodes answer 0 with status[0].
  function automatic logic [19:0] model_tx(input logic [19:0] f, input logic e);
    if (f[19:16] >= 4'd12) return 20'h10000;
    return {2'b00, e, 1'b0, alu_fn(f[19:16], f[15:8], f[7:0])};
  endfunction

  function automatic void queue_cmd(input logic [19:0] f, input int lat, input logic e, input logic [19:0] exp_tx);
    exp_q.push_back(exp_tx);
    if (f[19:16] < 4'd12) begin
      cmd_q.push_back(f);
      lat_q.push_back(lat);
      err_q.push_back(e);
    end
  endfunction

  // ALU responder: lat cycles after start (0 = never answers).
  initial begin
    int          lat;
    logic        e;
    logic [15:0] r;
    alu_done = 1'b0; alu_result = '0; alu_err = 1'b0;
    forever begin
      @(negedge clk);
      if (alu_start && reset_n) begin
        lat = (lat_q.size() > 0) ? lat_q.pop_front() : 1;
        e   = (err_q.size() > 0) ? err_q.pop_front() : 1'b0;
        r   = alu_fn(alu_op, alu_a, alu_b);
        if (lat > 0) begin
          repeat (lat) @(posedge clk);
          #1; alu_done = 1'b1; alu_result = r; alu_err = e;
          @(posedge clk);
          #1; alu_done = 1'b0; alu_result = '0; alu_err = 1'b0;
        end
      end
    end
  end

  // Output monitor: every tx_load and alu_start is checked against the expectation queues.
  initial begin
    logic [19:0] f;
    forever begin
      @(negedge clk);
      if (reset_n && tx_load) begin
        load_count++;
        load_cyc_q.push_back(cyc);
        if (exp_q.size() == 0) check("tx_unexpected", {12'd0, tx_data}, 32'hFFFFFFFF);
        else check("tx_data", {12'd0, tx_data}, {12'd0, exp_q.pop_front()});
      end
      if (reset_n && alu_start) begin
        start_count++;
        start_cyc_q.push_back(cyc);
        if (cmd_q.size() == 0) check("start_unexpected", {28'd0, alu_op}, 32'hFFFFFFFF);
        else begin
          f = cmd_q.pop_front();
          check("alu_cmd", {12'd0, alu_op, alu_a, alu_b}, {12'd0, f});
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

  task automatic send_at(input logic [19:0] f, input int target);
    while (cyc < target) begin
      @(posedge clk); #1;
    end
    frame_valid = 1'b1; frame_data = f;
    @(posedge clk); #1;
    frame_valid = 1'b0; frame_data = '0;
  endtask

  task automatic wait_loads(input int target, input int budget, input string name);
    int k;
    k = 0;
    while (load_count < target && k < budget) begin
      @(negedge clk); #1; k++;
    end
    check(name, (load_count >= target) ? 32'd1 : 32'd0, 32'd1);
  endtask

  task automatic wait_idle(input int budget);
    int k;
    k = 0;
    while (busy && k < budget) begin
      @(negedge clk); #1; k++;
    end
    check("idle_wait", {31'd0, busy}, 32'd0);
  endtask

  vec_t vecs[7];

  initial begin
    int t0, l0, s0, valid, g;
    logic [19:0] f1, f2;
    int lat1, lat2;
    logic e1, e2;

    vecs[0] = '{20'h01234, 2, 1'b0, 20'h00046, 4};
    vecs[1] = '{20'hEFF01, 0, 1'b0, 20'h10000, 1};
    vecs[2] = '{20'h15020, 1, 1'b0, 20'h00030, 3};
    vecs[3] = '{20'h21010, 3, 1'b1, 20'h20100, 5};
    vecs[4] = '{20'hC0000, 0, 1'b0, 20'h10000, 1};
    vecs[5] = '{20'hB0102, 1, 1'b0, 20'h0BAB9, 3};
    vecs[6] = '{20'h5F00F, 4, 1'b0, 20'h000FF, 6};

    reset_n = 1'b0; frame_valid = 1'b0; frame_data = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_outputs", {alu_start, tx_load, busy, alu_op, alu_a, alu_b, tx_data},
          32'd0);
    @(posedge clk); #1 reset_n = 1'b1;
    @(negedge clk);
    check("post_rst_busy", {31'd0, busy}, 32'd0);

    foreach (vecs[i]) begin
      valid = (vecs[i].exp_lat > 1);
      queue_cmd(vecs[i].frame, vecs[i].lat, vecs[i].err, vecs[i].exp_tx);
      l0 = load_count; s0 = start_count;
      load_cyc_q.delete(); start_cyc_q.delete();
      @(posedge clk); #1;
      t0 = cyc;
      send_at(vecs[i].frame, t0);
      wait_loads(l0 + 1, 100, "vec_load_wait");
      if (load_cyc_q.size() > 0) check("vec_latency", load_cyc_q[0] - t0, vecs[i].exp_lat);
      check("vec_starts", start_count - s0, valid);
      if (valid != 0 && start_cyc_q.size() > 0) check("vec_start_cycle", start_cyc_q[0] - t0, 1);
      @(negedge clk);
      check("vec_busy_after", {31'd0, busy}, 32'd0);
    end

    // Pending + overrun: third frame dropped, first response flags it.
    exp_q.push_back(20'h80003); cmd_q.push_back(20'h00102); lat_q.push_back(20); err_q.push_back(1'b0);
    exp_q.push_back(20'h00030); cmd_q.push_back(20'h3F03C); lat_q.push_back(1);  err_q.push_back(1'b0);
    l0 = load_count; s0 = start_count;
    load_cyc_q.delete(); start_cyc_q.delete();
    @(posedge clk); #1;
    t0 = cyc;
    send_at(20'h00102, t0);
    send_at(20'h3F03C, t0 + 3);
    send_at(20'h41122, t0 + 5);
    wait_loads(l0 + 2, 100, "ovr_load_wait");
    repeat (10) @(negedge clk);
    check("ovr_starts", start_count - s0, 2);
    check("ovr_loads", load_count - l0, 2);
    if (load_cyc_q.size() >= 1) check("ovr_f1_load_cycle", load_cyc_q[0] - t0, 22);
    if (load_cyc_q.size() >= 1 && start_cyc_q.size() >= 2)
      check("ovr_b2b_start", start_cyc_q[1] - load_cyc_q[0], 1);
    wait_idle(50);

    // Refill on consume: third frame arrives in the LOAD that drains pending.
    exp_q.push_back(20'h000FF); cmd_q.push_back(20'h50FF0); lat_q.push_back(6); err_q.push_back(1'b0);
    exp_q.push_back(20'h00100); cmd_q.push_back(20'h08080); lat_q.push_back(2); err_q.push_back(1'b0);
    exp_q.push_back(20'h10000);
    l0 = load_count; s0 = start_count;
    load_cyc_q.delete(); start_cyc_q.delete();
    @(posedge clk); #1;
    t0 = cyc;
    send_at(20'h50FF0, t0);
    send_at(20'h08080, t0 + 3);
    send_at(20'hD0000, t0 + 8);
    wait_loads(l0 + 3, 100, "refill_load_wait");
    check("refill_starts", start_count - s0, 2);
    if (load_cyc_q.size() >= 3) begin
      check("refill_f1_load", load_cyc_q[0] - t0, 8);
      check("refill_f3_b2b", load_cyc_q[2] - load_cyc_q[1], 1);
    end
    wait_idle(50);

    // Reset while waiting on the ALU with a frame pending.
    cmd_q.push_back(20'h00505); lat_q.push_back(30); err_q.push_back(1'b0);
    @(posedge clk); #1;
    t0 = cyc;
    send_at(20'h00505, t0);
    send_at(20'h10303, t0 + 3);
    while (cyc < t0 + 6) begin
      @(posedge clk); #1;
    end
    reset_n = 1'b0;
    @(negedge clk);
    check("midrst_outputs", {alu_start, tx_load, busy, alu_op, alu_a, alu_b, tx_data},
          32'd0);
    @(posedge clk); #1 reset_n = 1'b1;
    l0 = load_count; s0 = start_count;
    repeat (40) @(negedge clk);
    check("midrst_no_load", load_count - l0, 0);
    check("midrst_no_start", start_count - s0, 0);
    check("midrst_busy", {31'd0, busy}, 32'd0);

    // Randomized single frames and pairs against the transaction model.
    for (int r = 0; r < 40; r++) begin
      f1 = {4'($urandom_range(0, 15)), 16'($urandom)};
      f2 = {4'($urandom_range(0, 15)), 16'($urandom)};
      lat1 = $urandom_range(1, 6); lat2 = $urandom_range(1, 6);
      e1 = 1'($urandom); e2 = 1'($urandom);
      g = $urandom_range(1, 8);
      l0 = load_count;
      queue_cmd(f1, lat1, e1, model_tx(f1, e1));
      @(posedge clk); #1;
      t0 = cyc;
      send_at(f1, t0);
      if (r % 2 == 1) begin
        queue_cmd(f2, lat2, e2, model_tx(f2, e2));
        send_at(f2, t0 + g);
        wait_loads(l0 + 2, 100, "rand_load_wait");
      end else begin
        wait_loads(l0 + 1, 100, "rand_load_wait");
      end
      wait_idle(50);
    end
    check("rand_queue_empty", exp_q.size(), 0);

`ifdef SPI_ALU_TIMEOUT_EN
    // Watchdog expiry, then a done exactly on the expiry cycle.
    exp_q.push_back(20'h40000); cmd_q.push_back(20'h00101); lat_q.push_back(0); err_q.push_back(1'b0);
    l0 = load_count; load_cyc_q.delete();
    @(posedge clk); #1;
    t0 = cyc;
    send_at(20'h00101, t0);
    wait_loads(l0 + 1, 200, "wd_load_wait");
    if (load_cyc_q.size() > 0) check("wd_latency", load_cyc_q[0] - t0, 66);
    wait_idle(50);
    exp_q.push_back(20'h00002); cmd_q.push_back(20'h00101); lat_q.push_back(64); err_q.push_back(1'b0);
    l0 = load_count; load_cyc_q.delete();
    @(posedge clk); #1;
    t0 = cyc;
    send_at(20'h00101, t0);
    wait_loads(l0 + 1, 200, "wd_edge_load_wait");
    if (load_cyc_q.size() > 0) check("wd_edge_latency", load_cyc_q[0] - t0, 66);
    wait_idle(50);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
